axi4lite_initiator: RTL
=======================

Name: axi4lite_initiator

Overview:
- AXI4-lite master (initiator) that converts the internal single-cycle wr_req/rd_req register bus into AXI4-lite transactions toward a downstream responder.
- It is the counterpart of the slave-side decoder, which turns AXI4-lite into wr_req/rd_req; this block drives AW/W/B/AR/R as initiator.
- One transaction is outstanding at a time. Bus errors are reported alongside the ack.

Parameters:
G_ADDR_WIDTH, 32, width of wr_addr_i/rd_addr_i/awaddr_o/araddr_o
G_PROT, 3'b000, constant value driven on awprot_o/arprot_o

Ports:
aclk  in  1  clock
areset_n  in  1  reset, asynchronous, active-low
wr_req_i  in  1  single-cycle write request pulse
wr_addr_i  in  G_ADDR_WIDTH  write byte address, sampled with wr_req_i
wr_data_i  in  32  write data, sampled with wr_req_i
wr_sel_i  in  32  per-bit write select; byte lane n enabled if any bit of [8n+7:8n] set
rd_req_i  in  1  single-cycle read request pulse
rd_addr_i  in  G_ADDR_WIDTH  read byte address, sampled with rd_req_i
busy_o  out  1  high when a new request cannot be accepted
wr_ack_o  out  1  single-cycle write completion
rd_ack_o  out  1  single-cycle read completion
rd_data_o  out  32  read data, valid with rd_ack_o
err_o  out  1  pulses with wr_ack_o/rd_ack_o when bresp/rresp != 2'b00
awvalid_o/awready_i/awaddr_o/awprot_o  out/in/out/out  1/1/G_ADDR_WIDTH/3  AW channel
wvalid_o/wready_i/wdata_o/wstrb_o  out/in/out/out  1/1/32/4  W channel
bvalid_i/bready_o/bresp_i  in/out/in  1/1/2  B channel
arvalid_o/arready_i/araddr_o/arprot_o  out/in/out/out  1/1/G_ADDR_WIDTH/3  AR channel
rvalid_i/rready_o/rdata_i/rresp_i  in/out/in/in  1/1/32/2  R channel

Behaviour:
- All outputs are registered.
- Reset values: every valid/ready/ack/err/busy output = 0; rd_data_o, address, data and wstrb outputs = 0. State = IDLE, pending read cleared.
- Async reset mid-transaction aborts immediately: valids drop, no ack is ever issued for the aborted request.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - On wr_req_i: latch awaddr/wdata, set wstrb_o[n] = |wr_sel_i[8n+7:8n]. Next cycle awvalid_o = wvalid_o = 1, busy_o = 1, state WR.
  - On rd_req_i only: latch araddr, arvalid_o = 1 next cycle, state RD_ADDR.
  - wr_req_i and rd_req_i in the same cycle: write is issued first, read address is latched as pending.
- WR:
  - awvalid_o and wvalid_o drop independently, the cycle after their own handshake (valid & ready sampled high). Either order or simultaneous acceptance is legal.
  - bready_o = 1 throughout WR and WR_RESP. Go to WR_RESP once both handshakes are done.
  - bvalid_i seen at a clock edge after both AW and W handshakes -> wr_ack_o = 1 the next cycle, err_o = (bresp_i != 0). bready_o drops.
  - Then, if a read is pending: go to RD_ADDR, arvalid_o = 1 in the same cycle as wr_ack_o. Otherwise go to IDLE, busy_o = 0 in the same cycle as wr_ack_o.
- RD_ADDR: arvalid_o held until arready_i is sampled high, then drops; state RD_DATA, rready_o = 1.
- RD_DATA: on rvalid_i, register rd_data_o <= rdata_i, rd_ack_o = 1 next cycle, err_o = (rresp_i != 0). rready_o drops, go to IDLE, busy_o = 0.
- Valid stability: once asserted, a valid and its payload are stable until handshake (AXI rule).
- Requests while busy_o = 1 are ignored: no AXI activity, no ack. This is a caller protocol violation.
- Minimum latency with ready tied high: request at cycle 0 -> valid at cycle 1 -> B/R at cycle 2 -> ack at cycle 3.
- A new request in the cycle of the ack (busy_o = 0) is accepted.

Test Plan:
1. Write, ready tied 1: wr_req_i at cycle 0, addr 0x10, data 0xCAFEF00D, sel 0x00FF00FF -> aw/wvalid_o at cycle 1, wstrb_o = 4'b0101, bvalid_i at cycle 2 with OKAY -> wr_ack_o at cycle 3, err_o = 0.
2. Skewed write: awready_i held low 5 cycles, wready_i high -> wvalid_o drops after 1 cycle, awvalid_o held with stable awaddr_o; no wr_ack_o before B; exactly one ack.
3. Read: rd_req_i, addr 0x4 -> arvalid_o/araddr_o = 0x4; arready_i delayed 3 cycles; rvalid_i with rdata_i = 0x12345678, rresp_i = 2'b10 -> rd_data_o = 0x12345678, rd_ack_o = 1, err_o = 1 for one cycle.
4. Simultaneous wr_req_i + rd_req_i (addrs 0x8/0xC) -> AW at 0x8 first, then arvalid_o with 0xC in the wr_ack_o cycle; rd_ack_o follows; busy_o high throughout.
5. Request while busy: second wr_req_i during WR -> no extra AW/W transaction, single wr_ack_o.
6. areset_n low mid-WR_RESP -> all valids and busy_o 0 immediately; late bvalid_i after reset release produces no ack.

Source files
------------

// File: rtl/axi4lite_initiator.sv
// AXI4-lite initiator: turns single-cycle wr_req/rd_req register-bus pulses
// into AXI4-lite transactions, one outstanding at a time, with bus errors
// reported alongside the completion ack.
module axi4lite_initiator #(
  parameter int         G_ADDR_WIDTH = 32,
  parameter logic [2:0] G_PROT       = 3'b000
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  // internal register-bus side
  input  logic                    wr_req_i,
  input  logic [G_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]             wr_data_i,
  input  logic [31:0]             wr_sel_i,
  input  logic                    rd_req_i,
  input  logic [G_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                    busy_o,
  output logic                    wr_ack_o,
  output logic                    rd_ack_o,
  output logic [31:0]             rd_data_o,
  output logic                    err_o,
  // AW channel
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [G_ADDR_WIDTH-1:0] awaddr_o,
  output logic [2:0]              awprot_o,
  // W channel
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [31:0]             wdata_o,
  output logic [3:0]              wstrb_o,
  // B channel
  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i,
  // AR channel
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [G_ADDR_WIDTH-1:0] araddr_o,
  output logic [2:0]              arprot_o,
  // R channel
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [31:0]             rdata_i,
  input  logic [1:0]              rresp_i
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   rd_pending;

  // A byte lane is written if any select bit inside that lane is set
  function automatic logic [3:0] sel_to_strb(input logic [31:0] sel);
    logic [3:0] strb;
    strb = '0;
    for (int n = 0; n < 4; n++) begin
      strb[n] = |sel[8*n +: 8];
    end
    return strb;
  endfunction

  // Protection attributes are fixed for every transaction
  assign awprot_o = G_PROT;
  assign arprot_o = G_PROT;

  // Transaction sequencer: all AXI and register-bus outputs are registered here
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rd_pending <= 1'b0;
      busy_o     <= 1'b0;
      wr_ack_o   <= 1'b0;
      rd_ack_o   <= 1'b0;
      rd_data_o  <= '0;
      err_o      <= 1'b0;
      awvalid_o  <= 1'b0;
      awaddr_o   <= '0;
      wvalid_o   <= 1'b0;
      wdata_o    <= '0;
      wstrb_o    <= '0;
      bready_o   <= 1'b0;
      arvalid_o  <= 1'b0;
      araddr_o   <= '0;
      rready_o   <= 1'b0;
    end else begin
      wr_ack_o <= 1'b0;
      rd_ack_o <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req_i) begin
            awaddr_o  <= wr_addr_i;
            wdata_o   <= wr_data_i;
            wstrb_o   <= sel_to_strb(wr_sel_i);
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
            bready_o  <= 1'b1;
            busy_o    <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= WR;
            // A simultaneous read waits behind the write
            if (rd_req_i) begin
              araddr_o   <= rd_addr_i;
              rd_pending <= 1'b1;
            end
          end else if (rd_req_i) begin
            araddr_o  <= rd_addr_i;
            arvalid_o <= 1'b1;
            busy_o    <= 1'b1;
            state     <= RD_ADDR;
          end
        end
        WR: begin
          if (awvalid_o && awready_i) begin
            awvalid_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (wvalid_o && wready_i) begin
            wvalid_o <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || (awvalid_o && awready_i)) &&
              (w_done  || (wvalid_o  && wready_i))) begin
            state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            bready_o <= 1'b0;
            wr_ack_o <= 1'b1;
            err_o    <= (bresp_i != 2'b00);
            if (rd_pending) begin
              rd_pending <= 1'b0;
              arvalid_o  <= 1'b1;
              state      <= RD_ADDR;
            end else begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        RD_ADDR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid_i) begin
            rd_data_o <= rdata_i;
            rd_ack_o  <= 1'b1;
            err_o     <= (rresp_i != 2'b00);
            rready_o  <= 1'b0;
            busy_o    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
